page_qbank: RTL and testbench

Parametrised bank of independent stream queues for a page's non-input streams. It handles NCH channels of uniform token width W, each with DEPTH entries and a configurable back-pressure slack. Every token carries a data word plus an end-of-stream flag (`_e`). The queues use the page's `_d/_e/_v/_b` handshake. The bank sits between a page's datapath outputs and the inter-page network, replacing per-stream hand-instantiated queues.

---
 rtl/page_qbank.sv | 107 ++++++++++
 tb/tb_page_qbank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/page_qbank.sv
// Bank of NCH independent {data, end-of-stream} circular-buffer queues with registered heads.
// Define PAGE_QBANK_STATS_EN to add per-channel high-water-mark outputs (hwm) and stats_clr.
module page_qbank #(
  parameter int NCH   = 4,
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int SLACK = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH*W-1:0] qin_d,
  input  logic [NCH-1:0]   qin_e,
  input  logic [NCH-1:0]   qin_v,
  output logic [NCH-1:0]   qin_b,
  output logic [NCH*W-1:0] qout_d,
  output logic [NCH-1:0]   qout_e,
  output logic [NCH-1:0]   qout_v,
  input  logic [NCH-1:0]   qout_b,
  output logic [NCH-1:0]   ovf,
  output logic [NCH*8-1:0] eos_cnt
`ifdef PAGE_QBANK_STATS_EN
  ,
  output logic [NCH*CW-1:0] hwm,
  input  logic              stats_clr
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] BP_CNT   = CW'(DEPTH - SLACK);

  for (genvar i = 0; i < NCH; i++) begin : gCh
    logic [W:0]    mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr, nextRd;
    logic [CW-1:0] count, nextCount;
    logic [W-1:0]  headD;
    logic          headE;
    logic          qinB, ovfR;
    logic [7:0]    eosR;
    logic          full, push, pop;
    logic [W:0]    inTok, nextHead;

    assign full      = (count == FULL_CNT);
    assign pop       = (count != '0) && !qout_b[i];
    assign push      = qin_v[i] && (!full || pop);
    assign nextCount = count + CW'(push) - CW'(pop);
    assign nextRd    = rdPtr + PW'(pop);
    assign inTok     = {qin_e[i], qin_d[i*W +: W]};

    // The incoming token becomes the head directly when it lands in the slot the
    // read pointer is about to point at; otherwise the head comes from storage.
    always_comb begin
      nextHead = '0;
      if (nextCount != '0) begin
        if (push && (wrPtr == nextRd)) nextHead = inTok;
        else                           nextHead = mem[nextRd];
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        count <= '0;
        wrPtr <= '0;
        rdPtr <= '0;
        headD <= '0;
        headE <= 1'b0;
        qinB  <= 1'b0;
        ovfR  <= 1'b0;
        eosR  <= '0;
      end else begin
        count <= nextCount;
        wrPtr <= wrPtr + PW'(push);
        rdPtr <= nextRd;
        headD <= nextHead[W-1:0];
        headE <= nextHead[W];
        qinB  <= (nextCount >= BP_CNT);
        if (qin_v[i] && full && !pop) ovfR <= 1'b1;
        if (pop && headE)             eosR <= eosR + 8'd1;
      end
    end

    always_ff @(posedge clock) begin
      if (push) mem[wrPtr] <= inTok;
    end

    assign qin_b[i]          = qinB;
    assign qout_d[i*W +: W]  = headD;
    assign qout_e[i]         = headE;
    assign qout_v[i]         = (count != '0);
    assign ovf[i]            = ovfR;
    assign eos_cnt[i*8 +: 8] = eosR;

`ifdef PAGE_QBANK_STATS_EN
    logic [CW-1:0] hwmR;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 hwmR <= '0;
      else if (stats_clr)         hwmR <= count;
      else if (nextCount > hwmR)  hwmR <= nextCount;
    end

    assign hwm[i*CW +: CW] = hwmR;
`endif
  end

endmodule

// File: tb/tb_page_qbank.sv
// Directed self-checking bench for page_qbank: fill/drain, overflow, sustained full
// throughput, SLACK back-pressure, end-of-stream counting, isolation and async reset.
module tb_page_qbank;
  localparam int NCH   = 4;
  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [NCH*W-1:0] qin_d, qout_d, d3, qout_d3;
  logic [NCH-1:0]   qin_e, qin_v, qin_b, qout_e, qout_v, qout_b, ovf;
  logic [NCH-1:0]   e3, v3, qin_b3, qout_e3, qout_v3, b3, ovf3;
  logic [NCH*8-1:0] eos_cnt, eos_cnt3;
`ifdef PAGE_QBANK_STATS_EN
  logic [NCH*CW-1:0] hwm, hwm3;
  logic              stats_clr;
`endif
  logic [4:0] eosPat;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  page_qbank #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .SLACK(0)) dut (
    .clock(clock), .reset(reset),
    .qin_d(qin_d), .qin_e(qin_e), .qin_v(qin_v), .qin_b(qin_b),
    .qout_d(qout_d), .qout_e(qout_e), .qout_v(qout_v), .qout_b(qout_b),
    .ovf(ovf), .eos_cnt(eos_cnt)
`ifdef PAGE_QBANK_STATS_EN
    , .hwm(hwm), .stats_clr(stats_clr)
`endif
  );

  page_qbank #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .SLACK(3)) dut3 (
    .clock(clock), .reset(reset),
    .qin_d(d3), .qin_e(e3), .qin_v(v3), .qin_b(qin_b3),
    .qout_d(qout_d3), .qout_e(qout_e3), .qout_v(qout_v3), .qout_b(b3),
    .ovf(ovf3), .eos_cnt(eos_cnt3)
`ifdef PAGE_QBANK_STATS_EN
    , .hwm(hwm3), .stats_clr(stats_clr)
`endif
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b0;
    qin_d  = '0;
    qin_e  = '0;
    qin_v  = '0;
    qout_b = '1;
    d3     = '0;
    e3     = '0;
    v3     = '0;
    b3     = '1;
    eosPat = 5'b11010;
`ifdef PAGE_QBANK_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    check("rst_qout_v", 64'(qout_v), 64'h0);
    check("rst_qin_b", 64'(qin_b), 64'h0);
    check("rst_ovf", 64'(ovf), 64'h0);
    check("rst_eos", 64'(eos_cnt), 64'h0);
    check("rst_qout_d", qout_d, 64'h0);
    tick;
    reset = 1'b1;

    // Fill ch0 with 0x0001..0x0010 while downstream stalls
    for (int k = 1; k <= 16; k++) begin
      qin_d[15:0] = 16'(k);
      qin_v[0]    = 1'b1;
      tick;
      if (k == 1) begin
        check("latency_v", 64'(qout_v[0]), 64'h1);
        check("latency_d", 64'(qout_d[15:0]), 64'h1);
      end
      if (k == 15) check("qinb_at15", 64'(qin_b[0]), 64'h0);
    end
    check("qinb_full", 64'(qin_b[0]), 64'h1);
    check("ovf_full", 64'(ovf[0]), 64'h0);
    check("head_full", 64'(qout_d[15:0]), 64'h1);

    // 17th token at full with no pop is dropped
    qin_d[15:0] = 16'hBEEF;
    tick;
    qin_v[0] = 1'b0;
    check("ovf_set", 64'(ovf[0]), 64'h1);
    check("qinb_after_ovf", 64'(qin_b[0]), 64'h1);

    qout_b[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check("drain_v", 64'(qout_v[0]), 64'h1);
      check("drain_d", 64'(qout_d[15:0]), 64'(k));
      tick;
    end
    check("drain_empty_v", 64'(qout_v[0]), 64'h0);
    check("drain_empty_d", 64'(qout_d[15:0]), 64'h0);
    check("drain_qinb", 64'(qin_b[0]), 64'h0);
    check("ovf_sticky", 64'(ovf[0]), 64'h1);

    #2 reset = 1'b0;
    #1 check("ovf_cleared", 64'(ovf[0]), 64'h0);
    #1 reset = 1'b1;

    // Refill, then push and pop together for 40 cycles across pointer wrap
    qout_b[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      qin_d[15:0] = 16'(16'h100 + k);
      qin_v[0]    = 1'b1;
      tick;
    end
    qout_b[0] = 1'b0;
    for (int j = 0; j < 40; j++) begin
      qin_d[15:0] = 16'(16'h200 + j);
      qin_v[0]    = 1'b1;
      check("sustain_d", 64'(qout_d[15:0]), (j < 16) ? 64'(16'h101 + j) : 64'(16'h200 + j - 16));
      tick;
    end
    qin_v[0] = 1'b0;
    check("sustain_qinb", 64'(qin_b[0]), 64'h1);
    check("sustain_ovf", 64'(ovf[0]), 64'h0);
    for (int j = 24; j < 40; j++) begin
      check("sustain_tail", 64'(qout_d[15:0]), 64'(16'h200 + j));
      tick;
    end
    check("sustain_empty", 64'(qout_v[0]), 64'h0);

    // SLACK=3: back-pressure from count 13, three more accepted
    for (int k = 1; k <= 16; k++) begin
      d3[15:0] = 16'(k);
      v3[0]    = 1'b1;
      tick;
      if (k == 12) check("slack_qinb12", 64'(qin_b3[0]), 64'h0);
      if (k == 13) check("slack_qinb13", 64'(qin_b3[0]), 64'h1);
    end
    check("slack_ovf16", 64'(ovf3[0]), 64'h0);
    tick;
    v3[0] = 1'b0;
    check("slack_ovf17", 64'(ovf3[0]), 64'h1);
    check("slack_head", 64'(qout_d3[15:0]), 64'h1);

    // ch1 stalled full, ch2 carries end-of-stream pattern 0,1,0,1,1
    qout_b = '1;
    for (int k = 1; k <= 16; k++) begin
      qin_d[31:16] = 16'(16'h300 + k);
      qin_v        = 4'b0010;
      tick;
    end
    for (int k = 0; k < 5; k++) begin
      qin_d[47:32] = 16'(16'h400 + k);
      qin_e[2]     = eosPat[k];
      qin_v        = 4'b0100;
      tick;
    end
    qin_v = '0;
    qin_e = '0;
    check("iso_ch1_head", 64'(qout_d[31:16]), 64'h301);
    check("eos_before", 64'(eos_cnt[23:16]), 64'h0);
    qout_b[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("eos_d", 64'(qout_d[47:32]), 64'(16'h400 + k));
      check("eos_e", 64'(qout_e[2]), 64'(eosPat[k]));
      tick;
    end
    check("eos_cnt2", 64'(eos_cnt[23:16]), 64'h3);
    check("eos_ch2_empty", 64'(qout_v[2]), 64'h0);
    check("iso_ch1_v", 64'(qout_v[1]), 64'h1);
    check("iso_ch1_qinb", 64'(qin_b[1]), 64'h1);
    check("iso_ch1_ovf", 64'(ovf[1]), 64'h0);
    qout_b[1] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check("iso_ch1_d", 64'(qout_d[31:16]), 64'(16'h300 + k));
      tick;
    end
    check("iso_ch1_eos", 64'(eos_cnt[15:8]), 64'h0);

    // Queue 8 tokens on every channel, then reset between edges
    qout_b = '1;
    for (int k = 1; k <= 8; k++) begin
      for (int c = 0; c < NCH; c++) qin_d[c*W +: W] = 16'(c * 256 + k);
      qin_e = '1;
      qin_v = '1;
      tick;
    end
    qin_v = '0;
    qin_e = '0;
    check("pre_rst_v", 64'(qout_v), 64'hF);
    check("pre_rst_e", 64'(qout_e), 64'hF);
    check("pre_rst_d", qout_d, 64'h0301_0201_0101_0001);
    #2 reset = 1'b0;
    #1;
    check("async_qout_v", 64'(qout_v), 64'h0);
    check("async_qout_d", qout_d, 64'h0);
    check("async_qout_e", 64'(qout_e), 64'h0);
    check("async_qin_b", 64'(qin_b), 64'h0);
    check("async_ovf", 64'(ovf), 64'h0);
    check("async_eos", 64'(eos_cnt), 64'h0);
    check("async_slack_qinb", 64'(qin_b3), 64'h0);
    check("async_slack_ovf", 64'(ovf3), 64'h0);
`ifdef PAGE_QBANK_STATS_EN
    check("async_hwm", 64'(hwm), 64'h0);
`endif
    #1 reset = 1'b1;
    tick;
    check("post_rst_v", 64'(qout_v), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
